// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the EX stage and the mul/div unit
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              abort;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module muldiv_unit #(
    parameter int DATA_W   = 32,
    parameter int FAST_MUL = 0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_dbz;
    logic                r_dbz_prev;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_b_zero;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [DATA_W-1:0]   r_mag_a;
    logic [DATA_W-1:0]   r_mag_b;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;

    logic                w_signed_op;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_fast_prod;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    // Even opcodes in the 0xx group are signed; unsigned ops keep raw operands.
    assign w_signed_op = ~bus.op[0];
    assign w_abs_a     = (w_signed_op && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    assign w_abs_b     = (w_signed_op && bus.b[DATA_W-1]) ? -bus.b : bus.b;

    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mag_b};

    assign w_fast_prod = {{DATA_W{1'b0}}, r_mag_a} * {{DATA_W{1'b0}}, r_mag_b};
    assign w_prod      = (FAST_MUL != 0) ? w_fast_prod : r_acc;
    assign w_prod_fix  = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo_fix   = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
    assign w_rem_fix   = r_sign_a ? -r_rem : r_rem;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_dbz_prev <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_b_zero   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                // A killed divide must not leave its accept-time flag clear behind.
                if (r_state != S_IDLE) begin
                    r_dbz <= r_dbz_prev;
                end
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.op[2]) begin
                            r_is_div   <= bus.op[1];
                            r_sign_a   <= w_signed_op & bus.a[DATA_W-1];
                            r_sign_b   <= w_signed_op & bus.b[DATA_W-1];
                            r_mag_a    <= w_abs_a;
                            r_mag_b    <= w_abs_b;
                            r_b_zero   <= (bus.b == '0);
                            r_cnt      <= '0;
                            r_acc      <= '0;
                            r_mcand    <= {{DATA_W{1'b0}}, w_abs_a};
                            r_rem      <= '0;
                            r_quo      <= w_abs_a;
                            r_dbz_prev <= r_dbz;
                            r_busy     <= 1'b1;
                            if (bus.op[1]) begin
                                r_dbz <= 1'b0;
                            end
                            if ((bus.op[1] && bus.b == '0) || (!bus.op[1] && FAST_MUL != 0)) begin
                                r_state <= S_FIX;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end else if (bus.start && bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.start && bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                    S_RUN: begin
                        if (r_is_div) begin
                            if (!w_diff[DATA_W]) begin
                                r_rem <= w_diff[DATA_W-1:0];
                                r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                            end else begin
                                r_rem <= w_rem_sh[DATA_W-1:0];
                                r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            if (r_mag_b[0]) begin
                                r_acc <= r_acc + r_mcand;
                            end
                            r_mcand <= {r_mcand[2*DATA_W-2:0], 1'b0};
                            r_mag_b <= {1'b0, r_mag_b[DATA_W-1:1]};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (r_is_div && r_b_zero) begin
                            r_dbz <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod_fix[DATA_W-1:0];
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (iterative and fast-multiply builds)
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_W(32)) if0 ();
    muldiv_unit_if #(.DATA_W(32)) if1 ();

    assign if0.start = start & ~sel;
    assign if0.op    = op;
    assign if0.a     = a;
    assign if0.b     = b;
    assign if0.abort = abort;
    assign if1.start = start & sel;
    assign if1.op    = op;
    assign if1.a     = a;
    assign if1.b     = b;
    assign if1.abort = abort;

    muldiv_unit #(.DATA_W(32), .FAST_MUL(0)) u_dut0 (
        .i_clk     (clk),
        .i_reset_n (resetn),
        .bus       (if0.slave)
    );

    muldiv_unit #(.DATA_W(32), .FAST_MUL(1)) u_dut1 (
        .i_clk     (clk),
        .i_reset_n (resetn),
        .bus       (if1.slave)
    );

    logic        busy_m, done_m, dbz_m;
    logic [31:0] hi_m, lo_m;
    assign busy_m = sel ? if1.busy        : if0.busy;
    assign done_m = sel ? if1.done        : if0.done;
    assign dbz_m  = sel ? if1.div_by_zero : if0.div_by_zero;
    assign hi_m   = sel ? if1.hi          : if0.hi;
    assign lo_m   = sel ? if1.lo          : if0.lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the Done cycle.
    task automatic do_op(input string tag, input bit s, input logic [2:0] o,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input int ebusy, input int acc_dbz, input int pulse_at);
        exp_t e;
        exp_t got_e;
        int   n;
        bit   got;
        e.hi = ehi; e.lo = elo; e.dbz = edbz; e.busy = ebusy;
        sb.push_back(e);
        sel = s; op = o; a = xa; b = xb; start = 1'b1;
        n = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            if (start) begin
                op = 3'b100;
                a  = 32'h0000DEAD;
            end
            if (i == 0 && acc_dbz >= 0) check({tag, ".acc_dbz"}, dbz_m, acc_dbz[0]);
            if (busy_m) n++;
            else got = 1'b1;
        end
        start = 1'b0;
        check({tag, ".done"}, done_m, 1'b1);
        got_e = sb.pop_front();
        check({tag, ".busy_cycles"}, n, got_e.busy);
        check({tag, ".hi"}, hi_m, got_e.hi);
        check({tag, ".lo"}, lo_m, got_e.lo);
        check({tag, ".dbz"}, dbz_m, got_e.dbz);
    endtask

    initial begin
        int seen_done;
        repeat (3) @(negedge clk);
        check("reset.busy", if0.busy, 1'b0);
        check("reset.done", if0.done, 1'b0);
        check("reset.dbz", if0.div_by_zero, 1'b0);
        check("reset.hi", if0.hi, 32'h0);
        check("reset.lo", if0.lo, 32'h0);
        check("reset.fast_busy", if1.busy, 1'b0);
        resetn = 1'b1;

        do_op("mult_iter", 1'b0, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1, -1);
        do_op("mult_fast", 1'b1, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, -1, -1);
        do_op("multu_max", 1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, -1, -1);
        check("b2b.in_done_cycle", done_m, 1'b1);
        do_op("mult_b2b", 1'b0, 3'b000, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, -1, -1);
        do_op("div_neg7_2", 1'b0, 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0, -1);
        do_op("div_min_m1", 1'b0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1, -1);
        do_op("divu_7_2", 1'b0, 3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, -1, -1);
        do_op("div_by_zero", 1'b0, 3'b010, 32'd5, 32'd0, 32'd1, 32'd3, 1'b1, 1, -1, -1);
        do_op("divu_9_3", 1'b0, 3'b011, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33, 0, -1);

        // Abort a multiply in its tenth RUN cycle.
        sel = 1'b0; op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.busy", if0.busy, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if0.done) seen_done++;
        end
        check("abort.no_done", seen_done, 0);
        check("abort.hi", if0.hi, 32'd0);
        check("abort.lo", if0.lo, 32'd3);

        do_op("divu_busy_start", 1'b0, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1, 5);

        op = 3'b100; a = 32'h00001234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mthi.hi", if0.hi, 32'h00001234);
        check("mthi.lo", if0.lo, 32'd14);
        check("mthi.busy", if0.busy, 1'b0);
        check("mthi.done", if0.done, 1'b0);

        op = 3'b101; a = 32'h00005555; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("mtlo_abort.lo", if0.lo, 32'd14);

        do_op("div_zero2", 1'b0, 3'b010, 32'd8, 32'd0, 32'h00001234, 32'd14, 1'b1, 1, 0, -1);

        // Aborted divide must restore the sticky flag it cleared on accept.
        op = 3'b011; a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_div.acc_dbz", if0.div_by_zero, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_div.dbz", if0.div_by_zero, 1'b1);
        check("abort_div.busy", if0.busy, 1'b0);

        do_op("div_7_m2", 1'b0, 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 0, -1);
        do_op("div_zero3", 1'b0, 3'b010, 32'd1, 32'd0, 32'd1, 32'hFFFFFFFD, 1'b1, 1, 0, -1);

        // Reset in the middle of a multiply.
        op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset.busy", if0.busy, 1'b0);
        check("midreset.hi", if0.hi, 32'd0);
        check("midreset.lo", if0.lo, 32'd0);
        check("midreset.dbz", if0.div_by_zero, 1'b0);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset.idle_after", if0.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS datapath.
- Sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Busy stalls the pipeline hazard logic. Abort lets a branch flush kill an operation in flight.
- Hi/Lo feed the MFHI/MFLO write-back path directly.

Parameters:
- DATA_W, 32: operand width. Hi and Lo are each DATA_W bits; the product is 2*DATA_W bits.
- FAST_MUL, 0:
  - 0 = shift-add multiply, one bit per cycle.
  - 1 = single-cycle multiply; the product is registered in the FIX cycle.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  operation request, sampled only in IDLE.
- Op  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- A  input  DATA_W  rs operand (dividend / multiplicand / MTxx data).
- B  input  DATA_W  rt operand (divisor / multiplier).
- Abort  input  1  flush: kills the current operation.
- Busy  output  1  high while an operation is in RUN or FIX.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result in that cycle.
- DivByZero  output  1  sticky flag; set by DIV/DIVU with B=0.
- Hi  output  DATA_W  HI register.
- Lo  output  DATA_W  LO register.

Behaviour:
- Reset (Reset=0 at an edge):
  - State goes to IDLE.
  - Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0.
  - Reset overrides every other input, including mid-operation.
- States:
  - IDLE: no operation in progress.
  - RUN: iteration counter runs 0..DATA_W-1.
  - FIX: sign correction, then Hi/Lo write.
- Busy is a registered copy of the state: it is 1 in RUN and FIX, 0 otherwise.
- IDLE, Start=1, Abort=0, Op=MULT/MULTU/DIV/DIVU: latch operands.
  - Signed ops latch |A|, |B|, sign of A and sign of B. Unsigned ops latch raw values with signs=0.
  - Go to RUN; with FAST_MUL=1 (multiply) or B=0 (divide), go directly to FIX.
  - DIV/DIVU clears DivByZero when accepted.
- IDLE, Start=1, Op=MTHI/MTLO: Hi (or Lo) <= A at that edge. State stays IDLE; no Busy, no Done.
- IDLE, Op=110/111: ignored.
- Start while Busy=1: ignored; no queueing. The pipeline must hold the instruction.
- Multiply iteration (RUN): a 2*DATA_W accumulator adds the multiplicand shifted by i when multiplier bit i is 1. RUN lasts exactly DATA_W cycles.
- Divide iteration (RUN): restoring division on magnitudes, one quotient bit per cycle, MSB first. RUN lasts exactly DATA_W cycles.
- FIX, one cycle, result written at its closing edge:
  - MULT: product is negated (two's complement, 2*DATA_W bits) if signA^signB. Hi = upper half, Lo = lower half.
  - DIV: Lo = quotient, negated if signA^signB. Hi = remainder, negated if signA.
  - Unsigned ops: no negation.
  - Divide by zero: Hi/Lo unchanged, DivByZero set to 1.
  - Done=1 during the cycle after the FIX edge. State returns to IDLE.
- Latency, counting from the accepting edge E0:
  - Iterative ops: Busy=1 for DATA_W+1 cycles (RUN DATA_W, FIX 1); Hi/Lo valid and Done=1 in the cycle after edge E(DATA_W+1).
  - FAST_MUL=1 multiply and divide by zero: Busy=1 for 1 cycle.
- Back-to-back: Start is accepted during the Done cycle, since the state is already IDLE.
- Overflow: signed MIN/-1 needs no special case; magnitude math yields Lo=MIN, Hi=0.
- Abort=1 at any edge:
  - State goes to IDLE; Busy=0 next cycle; no Done.
  - Hi, Lo and DivByZero keep their pre-operation values.
  - Abort with Start in the same IDLE cycle: Abort wins and Start is ignored, including MTHI/MTLO.
- Outputs Hi and Lo change only at FIX edges, MTxx edges and reset.

Test Plan:
- MULT, A=0xFFFFFFFD, B=7, FAST_MUL=0 -> Busy=1 for 33 cycles, then Done pulse, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Repeat with FAST_MUL=1 -> Busy=1 for 1 cycle, same result.
- MULTU, A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Immediately issue MULT 0x80000000 x 2 in the Done cycle -> accepted, Hi=0xFFFFFFFF, Lo=0x00000000.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU, A=7, B=2 -> Lo=3, Hi=1. DIV, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIV, A=5, B=0 after a prior result Hi=1, Lo=3 -> Busy=1 for 1 cycle, Done, DivByZero=1, Hi=1, Lo=3. Next DIVU 9/3 -> DivByZero=0 on accept, Lo=3, Hi=0.
- Start MULT, then Abort at RUN cycle 10 -> no Done, Busy=0 next cycle, Hi/Lo unchanged. Start pulsed during Busy -> ignored. Reset=0 mid-DIV -> Hi=Lo=0, Busy=0, DivByZero=0.
- MTHI, A=0x00001234 -> Hi=0x00001234 after one edge, Busy stays 0, no Done. MTLO together with Abort -> Lo unchanged.
